// File: rtl/morse_letter_sequencer.sv
// Morse letter sequencer: steers classified symbols into the 4x2-bit loader,
// pads short letters with blanks and hands finished letters downstream.
module morse_letter_sequencer #(
    parameter int READY_TIMEOUT = 8,
    parameter int TW            = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sym_valid,
    input  logic [1:0] sym_code,
    input  logic       letter_end,
    output logic       sym_ready,
    output logic       ld_enable,
    output logic       ld_load,
    output logic [1:0] ld_in,
    output logic       ld_rst_n,
    input  logic [7:0] ld_out,
    input  logic       ld_ready,
    output logic       letter_valid,
    output logic [7:0] letter_code,
    output logic [2:0] letter_len,
    input  logic       letter_accept,
    output logic       ovf_err,
    output logic       sym_err,
    output logic       to_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_PAD,
        S_WAIT_RDY,
        S_HOLD,
        S_DROP
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [2:0]    slot_q, slot_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    buf_q, buf_d;
    logic          rdy_seen_q, rdy_seen_d;

    logic          sym_ready_q, sym_ready_d;
    logic          ld_enable_q, ld_enable_d;
    logic          ld_load_q, ld_load_d;
    logic [1:0]    ld_in_q, ld_in_d;
    logic          ld_rst_n_q, ld_rst_n_d;
    logic          letter_valid_q, letter_valid_d;
    logic [7:0]    letter_code_q, letter_code_d;
    logic [2:0]    letter_len_q, letter_len_d;
    logic          ovf_err_q, ovf_err_d;
    logic          sym_err_q, sym_err_d;
    logic          to_err_q, to_err_d;

    logic          sym_take;
    logic          sym_legal;
    logic          sym_ok;
    logic          sym_bad;
    logic          end_take;
    logic [2:0]    cnt_inc;
    logic [7:0]    rdy_word;

    // Handshake is qualified by the registered ready, so the cycle
    // right after reset accepts nothing.
    assign sym_take  = sym_ready_q & sym_valid;
    assign sym_legal = (sym_code == 2'b01) | (sym_code == 2'b10);
    assign sym_ok    = sym_take & sym_legal;
    assign sym_bad   = sym_take & ~sym_legal;
    assign end_take  = sym_ready_q & letter_end;
    assign cnt_inc   = cnt_q + 3'd1;
    assign rdy_word  = ld_ready ? ld_out : buf_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        slot_d         = slot_q;
        tcnt_d         = tcnt_q;
        buf_d          = buf_q;
        rdy_seen_d     = rdy_seen_q;
        ld_load_d      = 1'b0;
        ld_in_d        = 2'b00;
        ld_rst_n_d     = 1'b1;
        letter_valid_d = letter_valid_q;
        letter_code_d  = letter_code_q;
        letter_len_d   = letter_len_q;
        ovf_err_d      = 1'b0;
        sym_err_d      = sym_bad;
        to_err_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (sym_ok) begin
                    cnt_d      = 3'd1;
                    ld_load_d  = 1'b1;
                    ld_in_d    = sym_code;
                    rdy_seen_d = 1'b0;
                    if (end_take) begin
                        state_d = S_PAD;
                        slot_d  = 3'd1;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end

            S_COLLECT: begin
                if (ld_ready) begin
                    buf_d      = ld_out;
                    rdy_seen_d = 1'b1;
                end
                if (sym_ok && cnt_q == 3'd4) begin
                    ovf_err_d = 1'b1;
                    state_d   = S_DROP;
                end else if (sym_ok) begin
                    cnt_d     = cnt_inc;
                    ld_load_d = 1'b1;
                    ld_in_d   = sym_code;
                    if (end_take && cnt_inc == 3'd4) begin
                        state_d = S_WAIT_RDY;
                        tcnt_d  = '0;
                    end else if (end_take) begin
                        state_d = S_PAD;
                        slot_d  = cnt_inc;
                    end
                end else if (end_take) begin
                    if (cnt_q == 3'd4 && (rdy_seen_q || ld_ready)) begin
                        state_d        = S_HOLD;
                        letter_valid_d = 1'b1;
                        letter_code_d  = rdy_word;
                        letter_len_d   = cnt_q;
                    end else if (cnt_q == 3'd4) begin
                        state_d = S_WAIT_RDY;
                        tcnt_d  = '0;
                    end else begin
                        state_d   = S_PAD;
                        slot_d    = cnt_inc;
                        ld_load_d = 1'b1;
                    end
                end
            end

            S_PAD: begin
                if (ld_ready) begin
                    buf_d      = ld_out;
                    rdy_seen_d = 1'b1;
                end
                // slot_q counts slots written, including this cycle's load.
                if (slot_q != 3'd4) begin
                    ld_load_d = 1'b1;
                    slot_d    = slot_q + 3'd1;
                end else begin
                    state_d = S_WAIT_RDY;
                    tcnt_d  = '0;
                end
            end

            S_WAIT_RDY: begin
                if (ld_ready || rdy_seen_q) begin
                    state_d        = S_HOLD;
                    letter_valid_d = 1'b1;
                    letter_code_d  = rdy_word;
                    letter_len_d   = cnt_q;
                end else if (tcnt_q == TW'(READY_TIMEOUT - 1)) begin
                    state_d    = S_IDLE;
                    cnt_d      = 3'd0;
                    rdy_seen_d = 1'b0;
                    to_err_d   = 1'b1;
                    ld_rst_n_d = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            S_HOLD: begin
                if (letter_accept) begin
                    state_d        = S_IDLE;
                    cnt_d          = 3'd0;
                    rdy_seen_d     = 1'b0;
                    letter_valid_d = 1'b0;
                end
            end

            S_DROP: begin
                if (end_take) begin
                    state_d    = S_IDLE;
                    cnt_d      = 3'd0;
                    rdy_seen_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        sym_ready_d = (state_d == S_IDLE) |
                      (state_d == S_COLLECT) |
                      (state_d == S_DROP);
        ld_enable_d = (state_d == S_COLLECT) |
                      (state_d == S_PAD) |
                      (state_d == S_WAIT_RDY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 3'd0;
            slot_q         <= 3'd0;
            tcnt_q         <= '0;
            buf_q          <= 8'h00;
            rdy_seen_q     <= 1'b0;
            sym_ready_q    <= 1'b0;
            ld_enable_q    <= 1'b0;
            ld_load_q      <= 1'b0;
            ld_in_q        <= 2'b00;
            ld_rst_n_q     <= 1'b1;
            letter_valid_q <= 1'b0;
            letter_code_q  <= 8'h00;
            letter_len_q   <= 3'd0;
            ovf_err_q      <= 1'b0;
            sym_err_q      <= 1'b0;
            to_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            slot_q         <= slot_d;
            tcnt_q         <= tcnt_d;
            buf_q          <= buf_d;
            rdy_seen_q     <= rdy_seen_d;
            sym_ready_q    <= sym_ready_d;
            ld_enable_q    <= ld_enable_d;
            ld_load_q      <= ld_load_d;
            ld_in_q        <= ld_in_d;
            ld_rst_n_q     <= ld_rst_n_d;
            letter_valid_q <= letter_valid_d;
            letter_code_q  <= letter_code_d;
            letter_len_q   <= letter_len_d;
            ovf_err_q      <= ovf_err_d;
            sym_err_q      <= sym_err_d;
            to_err_q       <= to_err_d;
        end
    end

    assign sym_ready    = sym_ready_q;
    assign ld_enable    = ld_enable_q;
    assign ld_load      = ld_load_q;
    assign ld_in        = ld_in_q;
    assign ld_rst_n     = ld_rst_n_q;
    assign letter_valid = letter_valid_q;
    assign letter_code  = letter_code_q;
    assign letter_len   = letter_len_q;
    assign ovf_err      = ovf_err_q;
    assign sym_err      = sym_err_q;
    assign to_err       = to_err_q;

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Bench for morse_letter_sequencer: loader model, letter-level reference
// model and a per-cycle comparator.
module tb_morse_letter_sequencer;

    localparam int RT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sym_valid = 1'b0;
    logic [1:0] sym_code = 2'b00;
    logic       letter_end = 1'b0;
    logic       sym_ready;
    logic       ld_enable;
    logic       ld_load;
    logic [1:0] ld_in;
    logic       ld_rst_n;
    logic [7:0] ld_out;
    logic       ld_ready;
    logic       letter_valid;
    logic [7:0] letter_code;
    logic [2:0] letter_len;
    logic       letter_accept = 1'b0;
    logic       ovf_err;
    logic       sym_err;
    logic       to_err;

    morse_letter_sequencer #(.READY_TIMEOUT(RT), .TW(4)) dut (
        .clk(clk), .rst(rst),
        .sym_valid(sym_valid), .sym_code(sym_code),
        .letter_end(letter_end), .sym_ready(sym_ready),
        .ld_enable(ld_enable), .ld_load(ld_load),
        .ld_in(ld_in), .ld_rst_n(ld_rst_n),
        .ld_out(ld_out), .ld_ready(ld_ready),
        .letter_valid(letter_valid), .letter_code(letter_code),
        .letter_len(letter_len), .letter_accept(letter_accept),
        .ovf_err(ovf_err), .sym_err(sym_err), .to_err(to_err)
    );

    always #5 clk = ~clk;

    // Loader: four 2-bit slots, ready one cycle after the fourth load.
    bit         stall = 1'b0;
    logic [7:0] lw;
    logic [1:0] lslot;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            lw <= 8'h00; lslot <= 2'd0; ld_out <= 8'h00; ld_ready <= 1'b0;
        end else if (!ld_rst_n) begin
            lw <= 8'h00; lslot <= 2'd0; ld_ready <= 1'b0;
        end else begin
            ld_ready <= 1'b0;
            if (ld_enable && ld_load) begin
                lw[7 - 2*lslot -: 2] <= ld_in;
                if (lslot == 2'd3) begin
                    ld_out   <= {lw[7:2], ld_in};
                    ld_ready <= !stall;
                end
                lslot <= lslot + 2'd1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: letters as lists of symbols.
    typedef struct { logic [7:0] code; logic [2:0] len; } letter_t;
    logic [1:0] exp_loads[$];
    letter_t    exp_letters[$];
    logic [1:0] cur[$];
    bit         over = 1'b0;
    int exp_ovf = 0, exp_sym = 0, exp_to = 0;
    int got_ovf = 0, got_sym = 0, got_to = 0, got_rstp = 0;

    task automatic model_accept(input logic v, input logic [1:0] c, input logic e);
        letter_t l;
        bit      just_ovf;
        just_ovf = 1'b0;
        if (v) begin
            if (c == 2'b01 || c == 2'b10) begin
                if (!over && cur.size() == 4) begin
                    over = 1'b1; just_ovf = 1'b1; exp_ovf++;
                end else if (!over) begin
                    cur.push_back(c); exp_loads.push_back(c);
                end
            end else begin
                exp_sym++;
            end
        end
        if (e && !just_ovf) begin
            if (over) begin
                over = 1'b0; cur.delete();
            end else if (cur.size() > 0) begin
                l.code = 8'h00;
                for (int i = 0; i < 4; i++) begin
                    if (i < cur.size()) l.code = {l.code[5:0], cur[i]};
                    else begin
                        l.code = {l.code[5:0], 2'b00};
                        exp_loads.push_back(2'b00);
                    end
                end
                l.len = 3'(cur.size());
                if (stall) exp_to++;
                else exp_letters.push_back(l);
                cur.delete();
            end
        end
    endtask

    task automatic model_flush();
        exp_loads.delete(); exp_letters.delete(); cur.delete(); over = 1'b0;
    endtask

    // Per-cycle comparator.
    int      cyc = 0;
    int      last_load = 0;
    bit      prev_valid = 1'b0;
    bit      have_exp = 1'b0;
    letter_t cur_exp;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_valid = 1'b0;
            end else begin
                if (ld_load) begin
                    chk("load_enable", int'(ld_enable), 1);
                    last_load = cyc;
                    if (exp_loads.size() == 0) chk("unexpected_load", 1, 0);
                    else chk("ld_in", int'(ld_in), int'(exp_loads.pop_front()));
                end
                if (letter_valid) begin
                    if (!prev_valid) begin
                        if (exp_letters.size() == 0) begin
                            have_exp = 1'b0;
                            chk("unexpected_letter", 1, 0);
                        end else begin
                            cur_exp = exp_letters.pop_front();
                            have_exp = 1'b1;
                        end
                    end
                    if (have_exp) begin
                        chk("model_code", int'(letter_code), int'(cur_exp.code));
                        chk("model_len", int'(letter_len), int'(cur_exp.len));
                    end
                    chk("hold_sym_ready", int'(sym_ready), 0);
                end
                prev_valid = letter_valid;
                if (ovf_err) got_ovf++;
                if (sym_err) got_sym++;
                if (!ld_rst_n) got_rstp++;
                if (to_err) begin
                    got_to++;
                    chk("to_latency", cyc - last_load, RT + 1);
                end
            end
        end
    end

    task automatic offer(input logic [1:0] c, input logic v, input logic e);
        bit ok;
        ok = 1'b0;
        sym_valid = v; sym_code = c; letter_end = e;
        for (int i = 0; i < 40; i++) begin
            if (sym_ready) begin
                ok = 1'b1;
                model_accept(v, c, e);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        sym_valid = 1'b0; letter_end = 1'b0;
        if (!ok) chk("offer_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (letter_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic take(input logic [7:0] code, input logic [2:0] len, input int hold);
        wait_valid();
        chk("letter_code", int'(letter_code), int'(code));
        chk("letter_len", int'(letter_len), int'(len));
        repeat (hold) @(negedge clk);
        letter_accept = 1'b1;
        @(negedge clk);
        letter_accept = 1'b0;
        chk("valid_after_accept", int'(letter_valid), 0);
    endtask

    function automatic int outs();
        return int'({sym_ready, ld_enable, ld_load, ld_in, ld_rst_n,
                     letter_valid, letter_code, letter_len,
                     ovf_err, sym_err, to_err});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 32'h0000_8000);
        rst = 1'b1;
        @(negedge clk);

        // E
        offer(2'b01, 1, 0); offer(2'b00, 0, 1);
        take(8'h40, 3'd1, 3);
        // H, end right after last symbol
        repeat (4) offer(2'b01, 1, 0);
        offer(2'b00, 0, 1);
        take(8'h55, 3'd4, 0);
        // H, loader ready captured before the end
        repeat (4) offer(2'b01, 1, 0);
        repeat (4) @(negedge clk);
        offer(2'b00, 0, 1);
        take(8'h55, 3'd4, 1);

        // Overflow then T
        repeat (5) offer(2'b01, 1, 0);
        repeat (2) @(negedge clk);
        chk("ovf_pulse", got_ovf, 1);
        offer(2'b00, 0, 1);
        for (int i = 0; i < 8; i++) begin
            chk("drop_no_letter", int'(letter_valid), 0);
            @(negedge clk);
        end
        offer(2'b10, 1, 0); offer(2'b00, 0, 1);
        take(8'h80, 3'd1, 0);

        // N with symbol and end together
        offer(2'b10, 1, 0); offer(2'b01, 1, 1);
        take(8'h90, 3'd2, 0);

        // Illegal codes
        offer(2'b00, 1, 0);
        offer(2'b01, 1, 0); offer(2'b11, 1, 0);
        offer(2'b10, 1, 0); offer(2'b00, 0, 1);
        take(8'h60, 3'd2, 0);
        chk("sym_err_count", got_sym, 2);

        // Backpressure
        offer(2'b10, 1, 0); offer(2'b00, 0, 1);
        wait_valid();
        chk("bp_code0", int'(letter_code), 8'h80);
        sym_valid = 1'b1; sym_code = 2'b01;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_sym_ready", int'(sym_ready), 0);
            chk("bp_code", int'(letter_code), 8'h80);
        end
        letter_accept = 1'b1;
        @(negedge clk);
        letter_accept = 1'b0;
        offer(2'b01, 1, 0);
        chk("bp_load", int'({ld_load, ld_in}), 3'b101);
        offer(2'b00, 0, 1);
        take(8'h40, 3'd1, 2);

        // Ready timeout
        stall = 1'b1;
        offer(2'b01, 1, 0); offer(2'b00, 0, 1);
        repeat (20) @(negedge clk);
        stall = 1'b0;
        chk("to_count", got_to, 1);
        chk("to_rst_pulse", got_rstp, 1);
        chk("to_idle_ready", int'(sym_ready), 1);
        offer(2'b10, 1, 0); offer(2'b00, 0, 1);
        take(8'h80, 3'd1, 0);

        // Reset while padding
        offer(2'b01, 1, 0); offer(2'b00, 0, 1);
        chk("pad_load", int'({ld_load, ld_in}), 3'b100);
        #2 rst = 1'b0;
        model_flush();
        #1 chk("midreset_outs", outs(), 32'h0000_8000);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        offer(2'b10, 1, 0); offer(2'b00, 0, 1);
        take(8'h80, 3'd1, 0);

        repeat (3) @(negedge clk);
        chk("total_ovf", got_ovf, exp_ovf);
        chk("total_sym_err", got_sym, exp_sym);
        chk("total_to", got_to, exp_to);
        chk("total_rst_pulse", got_rstp, exp_to);
        chk("loads_left", exp_loads.size(), 0);
        chk("letters_left", exp_letters.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
